// File: rtl/vscale_dmem_rr_arbiter.sv
// Round-robin arbiter sharing one HASTI dmem slave between two vscale cores.
// Optional VSCALE_ARB_PERF_EN adds per-core grant and stall counters.
module vscale_dmem_rr_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BUS_W   = 32,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] core_haddr_0,
  input  logic              core_hwrite_0,
  input  logic [2:0]        core_hsize_0,
  input  logic [2:0]        core_hburst_0,
  input  logic              core_hmastlock_0,
  input  logic [3:0]        core_hprot_0,
  input  logic [1:0]        core_htrans_0,
  input  logic [BUS_W-1:0]  core_hwdata_0,
  output logic [BUS_W-1:0]  core_hrdata_0,
  output logic              core_hready_0,
  output logic              core_hresp_0,
  input  logic [ADDR_W-1:0] core_haddr_1,
  input  logic              core_hwrite_1,
  input  logic [2:0]        core_hsize_1,
  input  logic [2:0]        core_hburst_1,
  input  logic              core_hmastlock_1,
  input  logic [3:0]        core_hprot_1,
  input  logic [1:0]        core_htrans_1,
  input  logic [BUS_W-1:0]  core_hwdata_1,
  output logic [BUS_W-1:0]  core_hrdata_1,
  output logic              core_hready_1,
  output logic              core_hresp_1,
  output logic [ADDR_W-1:0] dmem_haddr,
  output logic              dmem_hwrite,
  output logic [2:0]        dmem_hsize,
  output logic [2:0]        dmem_hburst,
  output logic              dmem_hmastlock,
  output logic [3:0]        dmem_hprot,
  output logic [1:0]        dmem_htrans,
  output logic [BUS_W-1:0]  dmem_hwdata,
  input  logic [BUS_W-1:0]  dmem_hrdata,
  input  logic              dmem_hready,
  input  logic              dmem_hresp,
`ifdef VSCALE_ARB_PERF_EN
  output logic [31:0]       perf_grant_0,
  output logic [31:0]       perf_grant_1,
  output logic [31:0]       perf_stall_0,
  output logic [31:0]       perf_stall_1,
`endif
  output logic              grant_core
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic       PRIO_INIT = (RR_INIT != 0);

  typedef struct packed {
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic              hmastlock;
    logic [3:0]        hprot;
  } addr_ph_t;

  addr_ph_t live_0, live_1, buf_0, buf_1, sel_0, sel_1, issued;
  logic     pend_0, pend_1;
  logic     dp_valid, dp_owner;
  logic     prio, grant_q;
  logic     live_req_0, live_req_1, cand_0, cand_1;
  logic     issue, gnt;

  assign live_0 = {core_haddr_0, core_hwrite_0, core_hsize_0, core_hburst_0,
                   core_hmastlock_0, core_hprot_0};
  assign live_1 = {core_haddr_1, core_hwrite_1, core_hsize_1, core_hburst_1,
                   core_hmastlock_1, core_hprot_1};

  // A core only sees the slave's hready while it owns the data phase.
  always_comb begin
    core_hready_0 = 1'b1;
    if (dp_valid && !dp_owner) core_hready_0 = dmem_hready;
    else if (pend_0)           core_hready_0 = 1'b0;
    core_hready_1 = 1'b1;
    if (dp_valid && dp_owner)  core_hready_1 = dmem_hready;
    else if (pend_1)           core_hready_1 = 1'b0;
  end

  // resetn gates live requests so nothing leaks onto the bus while in reset.
  assign live_req_0 = resetn && (core_htrans_0 == HT_NONSEQ) && core_hready_0;
  assign live_req_1 = resetn && (core_htrans_1 == HT_NONSEQ) && core_hready_1;
  assign cand_0     = pend_0 || live_req_0;
  assign cand_1     = pend_1 || live_req_1;
  assign issue      = dmem_hready && (cand_0 || cand_1);
  assign gnt        = (cand_0 && cand_1) ? prio : cand_1;

  assign sel_0  = pend_0 ? buf_0 : live_0;
  assign sel_1  = pend_1 ? buf_1 : live_1;
  assign issued = gnt ? sel_1 : sel_0;

  assign dmem_haddr     = issue ? issued.haddr     : '0;
  assign dmem_hwrite    = issue ? issued.hwrite    : 1'b0;
  assign dmem_hsize     = issue ? issued.hsize     : 3'b000;
  assign dmem_hburst    = issue ? issued.hburst    : 3'b000;
  assign dmem_hmastlock = issue ? issued.hmastlock : 1'b0;
  assign dmem_hprot     = issue ? issued.hprot     : 4'b0000;
  assign dmem_htrans    = issue ? HT_NONSEQ        : HT_IDLE;
  assign grant_core     = issue ? gnt              : grant_q;

  assign dmem_hwdata   = !dp_valid ? '0 : (dp_owner ? core_hwdata_1 : core_hwdata_0);
  assign core_hrdata_0 = (dp_valid && !dp_owner) ? dmem_hrdata : '0;
  assign core_hrdata_1 = (dp_valid &&  dp_owner) ? dmem_hrdata : '0;
  assign core_hresp_0  = dp_valid && !dp_owner && dmem_hresp;
  assign core_hresp_1  = dp_valid &&  dp_owner && dmem_hresp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_0   <= 1'b0;
      pend_1   <= 1'b0;
      buf_0    <= '0;
      buf_1    <= '0;
      dp_valid <= 1'b0;
      dp_owner <= 1'b0;
      prio     <= PRIO_INIT;
      grant_q  <= PRIO_INIT;
    end else begin
      if (issue) begin
        dp_valid <= 1'b1;
        dp_owner <= gnt;
        prio     <= ~gnt;
        grant_q  <= gnt;
      end else if (dmem_hready) begin
        dp_valid <= 1'b0;
      end
      // A pending request and a live accept are mutually exclusive per core.
      if (issue && !gnt) begin
        pend_0 <= 1'b0;
      end else if (live_req_0) begin
        pend_0 <= 1'b1;
        buf_0  <= live_0;
      end
      if (issue && gnt) begin
        pend_1 <= 1'b0;
      end else if (live_req_1) begin
        pend_1 <= 1'b1;
        buf_1  <= live_1;
      end
    end
  end

`ifdef VSCALE_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_grant_0 <= '0;
      perf_grant_1 <= '0;
      perf_stall_0 <= '0;
      perf_stall_1 <= '0;
    end else begin
      if (issue && !gnt) perf_grant_0 <= perf_grant_0 + 32'd1;
      if (issue &&  gnt) perf_grant_1 <= perf_grant_1 + 32'd1;
      if (pend_0)        perf_stall_0 <= perf_stall_0 + 32'd1;
      if (pend_1)        perf_stall_1 <= perf_stall_1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vscale_dmem_rr_arbiter.sv
// Directed bench for vscale_dmem_rr_arbiter: slave-side issue scoreboard plus
// immediate-assert checks of handshake, routing, reset and arbitration order.
module tb_vscale_dmem_rr_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] core_haddr_0, core_haddr_1, core_hwdata_0, core_hwdata_1;
  logic        core_hwrite_0, core_hwrite_1, core_hmastlock_0, core_hmastlock_1;
  logic [2:0]  core_hsize_0, core_hsize_1, core_hburst_0, core_hburst_1;
  logic [3:0]  core_hprot_0, core_hprot_1;
  logic [1:0]  core_htrans_0, core_htrans_1;
  logic [31:0] core_hrdata_0, core_hrdata_1;
  logic        core_hready_0, core_hready_1, core_hresp_0, core_hresp_1;
  logic [31:0] dmem_haddr, dmem_hwdata, dmem_hrdata;
  logic        dmem_hwrite, dmem_hmastlock, dmem_hready, dmem_hresp, grant_core;
  logic [2:0]  dmem_hsize, dmem_hburst;
  logic [3:0]  dmem_hprot;
  logic [1:0]  dmem_htrans;
`ifdef VSCALE_ARB_PERF_EN
  logic [31:0] perf_grant_0, perf_grant_1, perf_stall_0, perf_stall_1;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        core;
    logic [31:0] addr;
    logic        wr;
  } exp_t;
  exp_t sb[$];

  vscale_dmem_rr_arbiter #(.ADDR_W(32), .BUS_W(32), .RR_INIT(0)) dut (
    .clk(clk), .resetn(resetn),
    .core_haddr_0(core_haddr_0), .core_hwrite_0(core_hwrite_0), .core_hsize_0(core_hsize_0),
    .core_hburst_0(core_hburst_0), .core_hmastlock_0(core_hmastlock_0), .core_hprot_0(core_hprot_0),
    .core_htrans_0(core_htrans_0), .core_hwdata_0(core_hwdata_0), .core_hrdata_0(core_hrdata_0),
    .core_hready_0(core_hready_0), .core_hresp_0(core_hresp_0),
    .core_haddr_1(core_haddr_1), .core_hwrite_1(core_hwrite_1), .core_hsize_1(core_hsize_1),
    .core_hburst_1(core_hburst_1), .core_hmastlock_1(core_hmastlock_1), .core_hprot_1(core_hprot_1),
    .core_htrans_1(core_htrans_1), .core_hwdata_1(core_hwdata_1), .core_hrdata_1(core_hrdata_1),
    .core_hready_1(core_hready_1), .core_hresp_1(core_hresp_1),
    .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite), .dmem_hsize(dmem_hsize),
    .dmem_hburst(dmem_hburst), .dmem_hmastlock(dmem_hmastlock), .dmem_hprot(dmem_hprot),
    .dmem_htrans(dmem_htrans), .dmem_hwdata(dmem_hwdata), .dmem_hrdata(dmem_hrdata),
    .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
`ifdef VSCALE_ARB_PERF_EN
    .perf_grant_0(perf_grant_0), .perf_grant_1(perf_grant_1),
    .perf_stall_0(perf_stall_0), .perf_stall_1(perf_stall_1),
`endif
    .grant_core(grant_core)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave-side monitor: every NONSEQ must match the oldest expected issue.
  always @(negedge clk) begin
    #3;
    if (resetn === 1'b1 && dmem_htrans === 2'b10) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", dmem_haddr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_grant", {31'd0, grant_core}, {31'd0, e.core});
        chk("sb_haddr", dmem_haddr, e.addr);
        chk("sb_hwrite", {31'd0, dmem_hwrite}, {31'd0, e.wr});
      end
    end
  end

  task automatic set0(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [31:0] wd);
    core_htrans_0 = tr; core_haddr_0 = a; core_hwrite_0 = w; core_hwdata_0 = wd;
  endtask

  task automatic set1(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [31:0] wd);
    core_htrans_1 = tr; core_haddr_1 = a; core_hwrite_1 = w; core_hwdata_1 = wd;
  endtask

  task automatic push(input logic c, input logic [31:0] a, input logic w);
    exp_t e;
    e.core = c; e.addr = a; e.wr = w;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    set0(2'b00, 32'h0, 1'b0, 32'h0);
    set1(2'b00, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int acc0, acc1, run0, run1, max_run, budget;
    resetn = 1'b0;
    core_hsize_0 = 3'b010; core_hsize_1 = 3'b010;
    core_hburst_0 = 3'b000; core_hburst_1 = 3'b000;
    core_hmastlock_0 = 1'b0; core_hmastlock_1 = 1'b0;
    core_hprot_0 = 4'b0011; core_hprot_1 = 4'b0011;
    set0(2'b10, 32'h123, 1'b0, 32'h0);
    set1(2'b00, 32'h0, 1'b0, 32'h0);
    dmem_hready = 1'b1; dmem_hresp = 1'b0; dmem_hrdata = 32'hFFFF_FFFF;

    // Outputs held quiet in reset even with a live request on core 0.
    #1;
    chk("rst_htrans", {30'd0, dmem_htrans}, 32'd0);
    chk("rst_haddr", dmem_haddr, 32'd0);
    chk("rst_hready_0", {31'd0, core_hready_0}, 32'd1);
    chk("rst_hready_1", {31'd0, core_hready_1}, 32'd1);
    chk("rst_hrdata_0", core_hrdata_0, 32'd0);
    chk("rst_grant", {31'd0, grant_core}, 32'd0);
    @(negedge clk);
    set0(2'b00, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Core 0 alone: read 0x100 then write 0x104, back-to-back.
    @(negedge clk);
    set0(2'b10, 32'h100, 1'b0, 32'h0); push(1'b0, 32'h100, 1'b0);
    #1 chk("t1_hready_0_a", {31'd0, core_hready_0}, 32'd1);
    @(negedge clk);
    set0(2'b10, 32'h104, 1'b1, 32'h0); push(1'b0, 32'h104, 1'b1);
    dmem_hrdata = 32'hCAFE_0001;
    #1 chk("t1_hrdata_0", core_hrdata_0, 32'hCAFE_0001);
    chk("t1_hready_0_b", {31'd0, core_hready_0}, 32'd1);
    @(negedge clk);
    set0(2'b00, 32'h0, 1'b0, 32'hDEAD_BEEF);
    #1 chk("t1_hwdata", dmem_hwdata, 32'hDEAD_BEEF);
    chk("t1_idle", {30'd0, dmem_htrans}, 32'd0);
`ifdef VSCALE_ARB_PERF_EN
    @(negedge clk);
    #1 chk("t1_perf_grant_0", perf_grant_0, 32'd2);
`endif

    // Simultaneous requests after reset: core 0 first, core 1 from its buffer.
    do_reset();
    set0(2'b10, 32'h200, 1'b0, 32'h0); push(1'b0, 32'h200, 1'b0);
    set1(2'b10, 32'h300, 1'b0, 32'h0); push(1'b1, 32'h300, 1'b0);
    #1 chk("t2_grant_a", {31'd0, grant_core}, 32'd0);
    chk("t2_hready_1_a", {31'd0, core_hready_1}, 32'd1);
    @(negedge clk);
    set0(2'b00, 32'h0, 1'b0, 32'h0);
    set1(2'b00, 32'hBAD, 1'b1, 32'h0);
    dmem_hrdata = 32'h11;
    #1 chk("t2_hready_1_b", {31'd0, core_hready_1}, 32'd0);
    chk("t2_hrdata_0", core_hrdata_0, 32'h11);
    chk("t2_grant_b", {31'd0, grant_core}, 32'd1);
    @(negedge clk);
    dmem_hrdata = 32'h22;
    #1 chk("t2_hrdata_1", core_hrdata_1, 32'h22);
    chk("t2_hrdata_0_quiet", core_hrdata_0, 32'd0);
    chk("t2_hready_1_c", {31'd0, core_hready_1}, 32'd1);

    // Continuous contention: eight transfers that strictly alternate 0,1,0,1...
    for (int i = 0; i < 8; i++)
      push(i[0], ((i % 2) ? 32'h2000 : 32'h1000) + 32'(4 * (i / 2)), 1'b0);
    acc0 = 0; acc1 = 0; run0 = 0; run1 = 0; max_run = 0; budget = 0;
    while ((sb.size() != 0 || acc0 < 4 || acc1 < 4) && budget < 40) begin
      @(negedge clk);
      budget++;
      set0((acc0 < 4) ? 2'b10 : 2'b00, 32'h1000 + 32'(4 * acc0), 1'b0, 32'h0);
      set1((acc1 < 4) ? 2'b10 : 2'b00, 32'h2000 + 32'(4 * acc1), 1'b0, 32'h0);
      #1;
      if (acc0 < 4) run0 = core_hready_0 ? 0 : run0 + 1;
      if (acc1 < 4) run1 = core_hready_1 ? 0 : run1 + 1;
      if (run0 > max_run) max_run = run0;
      if (run1 > max_run) max_run = run1;
      if (core_htrans_0 == 2'b10 && core_hready_0) acc0++;
      if (core_htrans_1 == 2'b10 && core_hready_1) acc1++;
    end
    chk("t3_budget", (budget < 40) ? 32'd1 : 32'd0, 32'd1);
    chk("t3_max_stall", 32'(max_run), 32'd1);
    @(negedge clk);
    set0(2'b00, 32'h0, 1'b0, 32'h0);
    set1(2'b00, 32'h0, 1'b0, 32'h0);

    // Three wait states on a core 1 read while core 0 sits buffered.
    @(negedge clk);
    set1(2'b10, 32'h400, 1'b0, 32'h0); push(1'b1, 32'h400, 1'b0);
    @(negedge clk);
    set1(2'b00, 32'h0, 1'b0, 32'h0);
    set0(2'b10, 32'h500, 1'b0, 32'h0); push(1'b0, 32'h500, 1'b0);
    dmem_hready = 1'b0;
    #1 chk("t4_hready_1_w", {31'd0, core_hready_1}, 32'd0);
    chk("t4_idle_w1", {30'd0, dmem_htrans}, 32'd0);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      set0(2'b00, 32'h0, 1'b0, 32'h0);
      #1 chk("t4_hready_0_stall", {31'd0, core_hready_0}, 32'd0);
      chk("t4_idle_w", {30'd0, dmem_htrans}, 32'd0);
    end
    @(negedge clk);
    dmem_hready = 1'b1; dmem_hrdata = 32'h44;
    #1 chk("t4_hrdata_1", core_hrdata_1, 32'h44);
    chk("t4_hready_0_issue", {31'd0, core_hready_0}, 32'd0);
    chk("t4_issue", {30'd0, dmem_htrans}, 32'd2);
    @(negedge clk);
    dmem_hrdata = 32'h55;
    #1 chk("t4_hrdata_0", core_hrdata_0, 32'h55);
    chk("t4_hready_0_done", {31'd0, core_hready_0}, 32'd1);

    // Error response on a core 0 write; next contended grant follows prio.
    @(negedge clk);
    set0(2'b10, 32'h600, 1'b1, 32'h0); push(1'b0, 32'h600, 1'b1);
    @(negedge clk);
    set0(2'b00, 32'h0, 1'b0, 32'h0);
    dmem_hready = 1'b0; dmem_hresp = 1'b1;
    #1 chk("t5_hresp_0_a", {31'd0, core_hresp_0}, 32'd1);
    chk("t5_hresp_1_a", {31'd0, core_hresp_1}, 32'd0);
    chk("t5_hready_0_a", {31'd0, core_hready_0}, 32'd0);
    @(negedge clk);
    dmem_hready = 1'b1;
    set0(2'b10, 32'h610, 1'b0, 32'h0);
    set1(2'b10, 32'h700, 1'b0, 32'h0);
    push(1'b1, 32'h700, 1'b0); push(1'b0, 32'h610, 1'b0);
    #1 chk("t5_hresp_0_b", {31'd0, core_hresp_0}, 32'd1);
    chk("t5_hresp_1_b", {31'd0, core_hresp_1}, 32'd0);
    chk("t5_grant_b", {31'd0, grant_core}, 32'd1);
    @(negedge clk);
    dmem_hresp = 1'b0;
    set0(2'b00, 32'h0, 1'b0, 32'h0);
    set1(2'b00, 32'h0, 1'b0, 32'h0);
    #1 chk("t5_grant_c", {31'd0, grant_core}, 32'd0);
    @(negedge clk);

    // Reset pulse while core 1 is buffered: nothing replays afterwards.
    @(negedge clk);
    set0(2'b10, 32'h800, 1'b0, 32'h0); push(1'b0, 32'h800, 1'b0);
    @(negedge clk);
    set0(2'b00, 32'h0, 1'b0, 32'h0);
    set1(2'b10, 32'h900, 1'b0, 32'h0);
    dmem_hready = 1'b0;
    @(negedge clk);
    set1(2'b00, 32'h0, 1'b0, 32'h0);
    #1 chk("t6_hready_1_pend", {31'd0, core_hready_1}, 32'd0);
    #1 resetn = 1'b0;
    #1 chk("t6_rst_htrans", {30'd0, dmem_htrans}, 32'd0);
    chk("t6_rst_hready_0", {31'd0, core_hready_0}, 32'd1);
    chk("t6_rst_hready_1", {31'd0, core_hready_1}, 32'd1);
    chk("t6_rst_grant", {31'd0, grant_core}, 32'd0);
`ifdef VSCALE_ARB_PERF_EN
    chk("t6_perf_grant_0", perf_grant_0, 32'd0);
    chk("t6_perf_grant_1", perf_grant_1, 32'd0);
    chk("t6_perf_stall_0", perf_stall_0, 32'd0);
    chk("t6_perf_stall_1", perf_stall_1, 32'd0);
`endif
    @(negedge clk);
    resetn = 1'b1; dmem_hready = 1'b1;
    #1 chk("t6_no_replay", {30'd0, dmem_htrans}, 32'd0);
    chk("t6_hready_1_after", {31'd0, core_hready_1}, 32'd1);
    @(negedge clk);
    #1 chk("t6_no_replay_2", {30'd0, dmem_htrans}, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vscale_dmem_rr_arbiter.md
Name: vscale_dmem_rr_arbiter

Overview:
- Shares the single HASTI data-memory slave port between vscale core 0 and core 1 dmem masters.
- Replaces externally driven core selection with an internal round-robin scheduler.
- Buffers one address phase per core and sequences AHB-lite address and data phases so that at most one transaction is outstanding at the slave.
- Sits between both cores' dmem ports and the shared dmem in the multicore sim top.

Parameters:
ADDR_W, 32, HASTI address width
BUS_W, 32, HASTI data bus width
RR_INIT, 0, core given priority first after reset (0 or 1)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
core_haddr_0/1  input  ADDR_W  core address phase
core_hwrite_0/1  input  1  write strobe
core_hsize_0/1  input  3  transfer size
core_hburst_0/1  input  3  burst (SINGLE only honoured)
core_hmastlock_0/1  input  1  lock (forwarded)
core_hprot_0/1  input  4  protection
core_htrans_0/1  input  2  IDLE=0 / NONSEQ=2
core_hwdata_0/1  input  BUS_W  write data (data phase)
core_hrdata_0/1  output  BUS_W  read data to core
core_hready_0/1  output  1  ready to core
core_hresp_0/1  output  1  response to core
dmem_haddr, dmem_hwrite, dmem_hsize, dmem_hburst, dmem_hmastlock, dmem_hprot, dmem_htrans, dmem_hwdata  output  as core  slave-side mux outputs
dmem_hrdata  input  BUS_W  slave read data
dmem_hready  input  1  slave ready
dmem_hresp  input  1  slave response
grant_core  output  1  core owning the current slave address phase (debug)

Behaviour:
- Clock is clk; reset is asynchronous and active-low on resetn. Reset clears all pend_c, dp_valid, and prio; prio resets to RR_INIT.
- Outputs during reset: dmem_htrans=IDLE, all other dmem_* = 0, core_hready_0/1=1, core_hresp=OKAY, core_hrdata=0, grant_core=RR_INIT.
- Accept: core c has a request when core_htrans_c==NONSEQ and core_hready_c==1 at a clk edge. If it is not issued to the slave that same cycle, latch {haddr, hwrite, hsize, hburst, hmastlock, hprot} into buffer c and set pend_c.
- Issue condition: slave address phase is free when dmem_hready==1 (any previous data phase completes this cycle, or none is active).
- Candidates: a core with pend_c set, or a live accepting NONSEQ. Buffered requests are presented from the buffer.
- Arbitration: if both cores are candidates, grant the core indicated by prio. After every grant, prio = ~granted core.
- Issue: drive the granted request on dmem_* with htrans=NONSEQ; set grant_core. At the edge, set dp_valid=1, dp_owner=granted, and clear pend_granted. If nothing is issued, dmem_htrans=IDLE.
- Data phase: dmem_hwdata = core_hwdata_{dp_owner}; core_hrdata_{dp_owner} = dmem_hrdata; core_hresp_{dp_owner} = dmem_hresp. The completing edge (dmem_hready==1) clears dp_valid unless a new issue sets it.
- core_hready_c:
  - = dmem_hready when dp_valid and dp_owner==c;
  - = 0 when pend_c, or when c was granted but its data phase has not started;
  - = 1 otherwise.
- Latency: an uncontended transfer adds 0 cycles. A losing core is stalled by one slave transaction.
- Simultaneous accept by both cores in one cycle: the winner issues; the loser is buffered and issues at the next dmem_hready.
- hburst other than SINGLE is forwarded as-is but scheduled per beat. Lock does not hold the grant.
- Error response (dmem_hresp=ERROR) is routed only to dp_owner. Arbitration state is unaffected.
- resetn asserted mid-transaction: drop buffered requests and the data phase immediately; no replay.

Optional Feature:
- Macro: VSCALE_ARB_PERF_EN.
- When defined: add outputs perf_grant_0/1 (32-bit, +1 per issue by that core) and perf_stall_0/1 (32-bit, +1 per cycle with pend_c set). Counters wrap at 2^32 and reset to 0.
- When undefined: these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Core0 alone issues read 0x100, then write 0x104 data 0xDEADBEEF, with dmem_hready=1 -> dmem_htrans NONSEQ back-to-back, no stall, core_hrdata_0 equals slave data, dmem_hwdata=0xDEADBEEF in the data phase.
- Both cores issue NONSEQ in the same cycle after reset with RR_INIT=0 -> core0 issued first; core1 buffered with core_hready_1=0 and issued next cycle with its original haddr; grant_core 0 then 1.
- Both cores issue continuously for 8 transfers -> grants strictly alternate 0,1,0,1; no core waits more than one transaction.
- Slave inserts 3 wait states (dmem_hready=0) on a core1 read while core0 is pending -> core0 stays stalled; core0 issues on the cycle dmem_hready returns to 1.
- dmem_hresp=ERROR on a core0 transfer -> core_hresp_0=1, core_hresp_1=0, and the next grant follows prio.
- resetn pulsed low while core1 is buffered -> all pend cleared, dmem_htrans=IDLE, core_hready both 1; with VSCALE_ARB_PERF_EN, counters read 0.
